stream_packet_fifo: RTL and testbench

Avalon-ST packet FIFO that sits directly downstream of the endian swapper and absorbs its output stream, decoupling it from sink backpressure. Stores data, empty, startofpacket and endofpacket per beat in a DEPTH-entry buffer and presents them first-word-fall-through. Tracks input framing, counting packets and framing errors. A small Avalon-MM CSR exposes fill level and a flush control.

---
 rtl/stream_fifo_pkg.sv | 33 +++
 rtl/stream_fifo_mem.sv | 35 +++
 rtl/stream_packet_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_stream_packet_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg
//   Shared definitions for the stream packet FIFO:
//   - CSR word addresses (ADDR_FILL, ADDR_CTRL, ADDR_PKTS, ADDR_ERRS)
//   - framing state enum for the input packet tracker
//   - beat struct (data, empty, sop, eop) at the default beat size, and a
//     helper giving the packed beat width for any DATA_BYTES
package stream_fifo_pkg;

   localparam int BEAT_BYTES = 8;

   localparam logic [1:0] ADDR_FILL = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_PKTS = 2'd2;
   localparam logic [1:0] ADDR_ERRS = 2'd3;

   typedef enum logic {
      FRAME_IDLE   = 1'b0,
      FRAME_IN_PKT = 1'b1
   } frame_state_e;

   // Field order matches the packed beat stored in the FIFO memory.
   typedef struct packed {
      logic [BEAT_BYTES*8-1:0]         data;
      logic [$clog2(BEAT_BYTES)-1:0]   empty;
      logic                            sop;
      logic                            eop;
   } beat_t;

   function automatic int beat_bits(input int data_bytes);
      return data_bytes * 8 + $clog2(data_bytes) + 2;
   endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem
//   DEPTH x WIDTH register array, one synchronous write port and one
//   asynchronous read port (used for first-word-fall-through head access).
//   Ports:
//     clk    - clock
//     we     - write enable
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address
//     rdata  - read data (combinational from raddr)
module stream_fifo_mem #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is not reset: contents are only observable while the
   // occupancy count says the entry is live.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stream_packet_fifo.sv
// stream_packet_fifo
//   Avalon-ST packet FIFO (readyLatency 0, first-word-fall-through) with a
//   small Avalon-MM CSR (readLatency 1).
//   Optional feature macro: STREAM_PACKET_FIFO_STATS_EN
//     defined     - framing tracker, packet counter and framing error
//                   counter are built; CSR addr 2/3 return the counters
//     not defined - tracker and counters removed; addr 2/3 read 0
//   Ports:
//     clk, reset_n              - clock, asynchronous active-low reset
//     stream_in_*               - upstream sink interface (data, empty,
//                                 valid, sop, eop, ready)
//     stream_out_*              - downstream source interface, fields are
//                                 the head entry while valid
//     csr_address/read/write    - CSR select and strobes
//     csr_writedata             - write data (addr 1 bit 0 = flush)
//     csr_readdata/valid        - registered read response
//     csr_waitrequest           - stall, only asserted during reset
//   Handshake: a beat moves on any edge where valid and ready are both high;
//   ready does not depend on valid, and valid does not wait for ready.
import stream_fifo_pkg::*;

module stream_packet_fifo #(
   parameter int DATA_BYTES = 8,
   parameter int DEPTH      = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DATA_BYTES*8-1:0]       stream_in_data,
   input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
   input  logic                          stream_in_valid,
   input  logic                          stream_in_startofpacket,
   input  logic                          stream_in_endofpacket,
   output logic                          stream_in_ready,
   output logic [DATA_BYTES*8-1:0]       stream_out_data,
   output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
   output logic                          stream_out_valid,
   output logic                          stream_out_startofpacket,
   output logic                          stream_out_endofpacket,
   input  logic                          stream_out_ready,
   input  logic [1:0]                    csr_address,
   input  logic                          csr_read,
   input  logic                          csr_write,
   input  logic [31:0]                   csr_writedata,
   output logic [31:0]                   csr_readdata,
   output logic                          csr_readdatavalid,
   output logic                          csr_waitrequest
);

   localparam int BW = beat_bits(DATA_BYTES);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          flush;
   logic          beat_acc;
   logic [BW-1:0] wr_beat;
   logic [BW-1:0] rd_beat;
   logic [31:0]   pkts_rd;
   logic [31:0]   errs_rd;
   logic [31:0]   csr_mux;
   logic          unused_wdata;

   assign unused_wdata = ^csr_writedata[31:1];

   // Full blocks the push even when a pop happens in the same cycle.
   assign stream_in_ready  = reset_n & (count != CW'(DEPTH));
   assign stream_out_valid = (count != '0);
   assign push             = stream_in_valid & stream_in_ready;
   assign pop              = stream_out_valid & stream_out_ready;

   assign csr_waitrequest  = ~reset_n;
   assign flush            = csr_write & ~csr_waitrequest &
                             (csr_address == ADDR_CTRL) & csr_writedata[0];
   // A push landing in the flush cycle is dropped entirely.
   assign beat_acc         = push & ~flush;

   assign wr_beat = {stream_in_data, stream_in_empty,
                     stream_in_startofpacket, stream_in_endofpacket};
   assign {stream_out_data, stream_out_empty,
           stream_out_startofpacket, stream_out_endofpacket} = rd_beat;

   stream_fifo_mem #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (beat_acc),
      .waddr (wr_ptr),
      .wdata (wr_beat),
      .raddr (rd_ptr),
      .rdata (rd_beat)
   );

   // Pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef STREAM_PACKET_FIFO_STATS_EN
   frame_state_e frame_state;
   frame_state_e frame_next;
   logic         frame_err;
   logic [31:0]  pkt_count;
   logic [31:0]  err_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_state <= FRAME_IDLE;
      end else if (flush) begin
         frame_state <= FRAME_IDLE;
      end else begin
         frame_state <= frame_next;
      end
   end

   // sop & eop together is a complete one-beat packet, so the tracker
   // returns to (or stays in) IDLE whenever eop is seen.
   always_comb begin
      frame_next = frame_state;
      if (beat_acc) begin
         case (frame_state)
            FRAME_IDLE: begin
               if (stream_in_startofpacket && !stream_in_endofpacket) begin
                  frame_next = FRAME_IN_PKT;
               end
            end
            FRAME_IN_PKT: begin
               if (stream_in_endofpacket) begin
                  frame_next = FRAME_IDLE;
               end
            end
            default: frame_next = FRAME_IDLE;
         endcase
      end
   end

   always_comb begin
      frame_err = 1'b0;
      if (beat_acc) begin
         case (frame_state)
            FRAME_IDLE:   frame_err = ~stream_in_startofpacket;
            FRAME_IN_PKT: frame_err = stream_in_startofpacket;
            default:      frame_err = 1'b0;
         endcase
      end
   end

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_count <= '0;
         err_count <= '0;
      end else begin
         if (beat_acc && stream_in_endofpacket) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (frame_err && (err_count != 32'hFFFF_FFFF)) begin
            err_count <= err_count + 32'd1;
         end
      end
   end

   assign pkts_rd = pkt_count;
   assign errs_rd = err_count;
`else
   assign pkts_rd = '0;
   assign errs_rd = '0;
`endif

   always_comb begin
      csr_mux = '0;
      case (csr_address)
         ADDR_FILL: csr_mux = 32'(count);
         ADDR_CTRL: csr_mux = '0;
         ADDR_PKTS: csr_mux = pkts_rd;
         ADDR_ERRS: csr_mux = errs_rd;
         default:   csr_mux = '0;
      endcase
   end

   // Read response samples state before the strobe edge, presented for
   // exactly one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csr_readdatavalid <= 1'b0;
         csr_readdata      <= '0;
      end else begin
         csr_readdatavalid <= csr_read;
         csr_readdata      <= csr_read ? csr_mux : '0;
      end
   end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// tb_stream_packet_fifo
//   Directed bench for stream_packet_fifo (DATA_BYTES 8, DEPTH 16) with a
//   queue scoreboard of accepted beats checked against the output stream.
module tb_stream_packet_fifo;
   import stream_fifo_pkg::*;

   localparam int DATA_BYTES = 8;
   localparam int DEPTH      = 16;

   logic        clk;
   logic        reset_n;
   logic [63:0] stream_in_data;
   logic [2:0]  stream_in_empty;
   logic        stream_in_valid;
   logic        stream_in_startofpacket;
   logic        stream_in_endofpacket;
   logic        stream_in_ready;
   logic [63:0] stream_out_data;
   logic [2:0]  stream_out_empty;
   logic        stream_out_valid;
   logic        stream_out_startofpacket;
   logic        stream_out_endofpacket;
   logic        stream_out_ready;
   logic [1:0]  csr_address;
   logic        csr_read;
   logic        csr_write;
   logic [31:0] csr_writedata;
   logic [31:0] csr_readdata;
   logic        csr_readdatavalid;
   logic        csr_waitrequest;

   logic [68:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   stream_packet_fifo #(
      .DATA_BYTES (DATA_BYTES),
      .DEPTH      (DEPTH)
   ) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .stream_in_data           (stream_in_data),
      .stream_in_empty          (stream_in_empty),
      .stream_in_valid          (stream_in_valid),
      .stream_in_startofpacket  (stream_in_startofpacket),
      .stream_in_endofpacket    (stream_in_endofpacket),
      .stream_in_ready          (stream_in_ready),
      .stream_out_data          (stream_out_data),
      .stream_out_empty         (stream_out_empty),
      .stream_out_valid         (stream_out_valid),
      .stream_out_startofpacket (stream_out_startofpacket),
      .stream_out_endofpacket   (stream_out_endofpacket),
      .stream_out_ready         (stream_out_ready),
      .csr_address              (csr_address),
      .csr_read                 (csr_read),
      .csr_write                (csr_write),
      .csr_writedata            (csr_writedata),
      .csr_readdata             (csr_readdata),
      .csr_readdatavalid        (csr_readdatavalid),
      .csr_waitrequest          (csr_waitrequest)
   );

   function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef STREAM_PACKET_FIFO_STATS_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] d, input logic [2:0] e, input logic s, input logic eo);
      stream_in_data          = d;
      stream_in_empty         = e;
      stream_in_startofpacket = s;
      stream_in_endofpacket   = eo;
      stream_in_valid         = 1'b1;
      tick();
      stream_in_valid         = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      csr_address = a;
      csr_read    = 1'b1;
      tick();
      csr_read    = 1'b0;
      chk("csr_readdatavalid", csr_readdatavalid, 1'b1);
      d = csr_readdata;
   endtask

   task automatic drain();
      int n = 0;
      stream_out_ready = 1'b1;
      while (stream_out_valid && n < 40) begin
         tick();
         n++;
      end
      stream_out_ready = 1'b0;
      chk("drain_valid_low", stream_out_valid, 1'b0);
      chk("drain_model_empty", exp_q.size(), 0);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
      end else if (csr_write && csr_address == ADDR_CTRL && csr_writedata[0]) begin
         exp_q.delete();
      end else begin
         chk("out_valid_vs_model", stream_out_valid, exp_q.size() != 0);
         if (stream_out_valid && stream_out_ready && exp_q.size() != 0) begin
            chk("out_beat", {stream_out_data, stream_out_empty,
                             stream_out_startofpacket, stream_out_endofpacket}, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (stream_in_valid && stream_in_ready) begin
            exp_q.push_back({stream_in_data, stream_in_empty,
                             stream_in_startofpacket, stream_in_endofpacket});
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset_n                 = 1'b0;
      stream_in_data          = '0;
      stream_in_empty         = '0;
      stream_in_valid         = 1'b0;
      stream_in_startofpacket = 1'b0;
      stream_in_endofpacket   = 1'b0;
      stream_out_ready        = 1'b0;
      csr_address             = '0;
      csr_read                = 1'b0;
      csr_write               = 1'b0;
      csr_writedata           = '0;

      repeat (3) tick();
      chk("rst_in_ready", stream_in_ready, 1'b0);
      chk("rst_out_valid", stream_out_valid, 1'b0);
      chk("rst_readdatavalid", csr_readdatavalid, 1'b0);
      chk("rst_readdata", csr_readdata, 32'd0);
      chk("rst_waitrequest", csr_waitrequest, 1'b1);
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", stream_in_ready, 1'b1);
      chk("post_rst_waitrequest", csr_waitrequest, 1'b0);
      tick();

      // three-beat packet held by the sink
      send(64'h1111, 3'd0, 1'b1, 1'b0);
      chk("valid_after_first_push", stream_out_valid, 1'b1);
      send(64'h2222, 3'd0, 1'b0, 1'b0);
      send(64'h3333, 3'd5, 1'b0, 1'b1);
      csr_rd(ADDR_FILL, rd);
      chk("fill_3", rd, 32'd3);
      tick();
      chk("readdatavalid_one_cycle", csr_readdatavalid, 1'b0);
      chk("head_data", stream_out_data, 64'h1111);
      chk("head_sop", stream_out_startofpacket, 1'b1);
      stream_out_ready = 1'b1;
      repeat (3) tick();
      stream_out_ready = 1'b0;
      chk("valid_low_after_3", stream_out_valid, 1'b0);

      // fill to DEPTH, hold the 17th beat
      for (int i = 0; i < 15; i++) send(64'hA000 + 64'(i), 3'd0, 1'b1, 1'b1);
      chk("ready_at_15", stream_in_ready, 1'b1);
      send(64'hA00F, 3'd0, 1'b1, 1'b1);
      chk("ready_low_at_16", stream_in_ready, 1'b0);
      stream_in_data  = 64'hA010;
      stream_in_valid = 1'b1;
      repeat (2) tick();
      chk("ready_low_held", stream_in_ready, 1'b0);
      csr_rd(ADDR_FILL, rd);
      chk("fill_16", rd, 32'd16);
      stream_out_ready = 1'b1;
      tick();
      stream_out_ready = 1'b0;
      chk("ready_after_pop_full", stream_in_ready, 1'b1);
      tick();
      stream_in_valid = 1'b0;
      chk("ready_low_refilled", stream_in_ready, 1'b0);
      drain();

      // simultaneous push/pop at count 5 across pointer wrap
      for (int i = 0; i < 5; i++) send(64'h5000 + 64'(i), 3'd1, 1'b1, 1'b1);
      stream_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         stream_in_data  = 64'h5100 + 64'(i);
         stream_in_empty = 3'(i);
         stream_in_valid = 1'b1;
         tick();
      end
      stream_in_valid  = 1'b0;
      stream_out_ready = 1'b0;
      csr_rd(ADDR_FILL, rd);
      chk("fill_5_steady", rd, 32'd5);
      drain();

      // framing errors: no-sop beat in IDLE, then sop twice
      send(64'h6000, 3'd0, 1'b0, 1'b0);
      send(64'h6001, 3'd0, 1'b1, 1'b0);
      send(64'h6002, 3'd0, 1'b1, 1'b0);
      csr_rd(ADDR_ERRS, rd);
      chk("errs_2", rd, stat(32'd2));
      csr_rd(ADDR_PKTS, rd);
      chk("pkts_before_eop", rd, stat(32'd33));
      send(64'h6003, 3'd7, 1'b0, 1'b1);
      csr_rd(ADDR_PKTS, rd);
      chk("pkts_after_eop", rd, stat(32'd34));
      csr_rd(ADDR_ERRS, rd);
      chk("errs_still_2", rd, stat(32'd2));
      drain();

      // flush with a push in the same cycle
      for (int i = 0; i < 7; i++) send(64'h7000 + 64'(i), 3'd0, 1'b1, 1'b1);
      csr_rd(ADDR_FILL, rd);
      chk("fill_7", rd, 32'd7);
      stream_in_data          = 64'h7777;
      stream_in_startofpacket = 1'b1;
      stream_in_endofpacket   = 1'b0;
      stream_in_valid         = 1'b1;
      csr_address             = ADDR_CTRL;
      csr_writedata           = 32'd1;
      csr_write               = 1'b1;
      tick();
      stream_in_valid = 1'b0;
      csr_write       = 1'b0;
      csr_writedata   = 32'd0;
      chk("flush_valid_low", stream_out_valid, 1'b0);
      chk("flush_ready_high", stream_in_ready, 1'b1);
      csr_rd(ADDR_FILL, rd);
      chk("flush_fill_0", rd, 32'd0);
      csr_rd(ADDR_CTRL, rd);
      chk("ctrl_reads_0", rd, 32'd0);
      csr_rd(ADDR_PKTS, rd);
      chk("pkts_survive_flush", rd, stat(32'd41));

      // reset mid-packet
      send(64'h8000, 3'd0, 1'b1, 1'b0);
      send(64'h8001, 3'd0, 1'b0, 1'b0);
      chk("pre_reset_valid", stream_out_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", stream_out_valid, 1'b0);
      chk("async_rst_ready", stream_in_ready, 1'b0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst2_valid", stream_out_valid, 1'b0);
      chk("post_rst2_ready", stream_in_ready, 1'b1);
      csr_rd(ADDR_FILL, rd);
      chk("post_rst2_fill", rd, 32'd0);
      csr_rd(ADDR_PKTS, rd);
      chk("post_rst2_pkts", rd, 32'd0);
      csr_rd(ADDR_ERRS, rd);
      chk("post_rst2_errs", rd, 32'd0);
      tick();

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
